seven_segment_decoder: RTL
==========================

# seven_segment_decoder

Recovers hexadecimal digits from a time-multiplexed, active-low seven-segment display bus: the segment-pattern/anode-select pair driven to the board displays. The block sits on the I/O side of the SoC as a loopback monitor for self-test of the display path, or as a capture front-end for an external display controller. It filters glitches during digit switching, decodes each stable pattern back to 4-bit hex, and holds per-digit value, valid and error status for software or bench readout.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digit positions (1–8).
- `STABLE_CYCLES`, default 16: consecutive identical synchronized samples required before a capture (≥2).

- `clk` input 1: single clock.
- `rst_n` input 1: synchronous, active-low reset.
- `seg_n` input 7: segment pattern, active-low; bit0 = a … bit6 = g.
- `an_n` input NUM_DIGITS: digit select, active-low, one-hot expected.
- `clear` input 1: synchronous clear of all digit status.
- `digits` output 4*NUM_DIGITS: captured hex values; digit i at [4i+3:4i].
- `digit_valid` output NUM_DIGITS: digit i holds a legally decoded value.
- `digit_err` output NUM_DIGITS: the last capture for digit i was an illegal pattern.
- `update` output 1: one-cycle pulse on every capture.

## Operation
- `seg_n` and `an_n` pass through a 2-flop synchronizer. Sample S = {an, seg} after synchronization.
- Stability counter:
  - Cleared to 0 when S differs from the previous S.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
  - `captured` flag is cleared on any change of S.
- Capture fires when the counter equals STABLE_CYCLES-1, `captured` = 0, and `an_n` has exactly one bit low. Firing sets `captured`, so there is one capture per stable period.
- If `an_n` has zero or multiple bits low, nothing is captured. That is a blanking or transition interval, not an error.
- Decode table (seg_n[6:0] → hex): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F.
- Capture on digit i, legal pattern: `digits[i]` ← decoded value, `digit_valid[i]` ← 1, `digit_err[i]` ← 0.
- Capture on digit i, illegal pattern: `digits[i]` is held, `digit_valid[i]` ← 0, `digit_err[i]` ← 1.
- `update` pulses in both cases.
- `clear`: all `digits`, `digit_valid` and `digit_err` go to 0, and `update` is suppressed that cycle. If `clear` coincides with a capture, `clear` wins and the capture is discarded, but `captured` is still set.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - `digits`, `digit_valid`, `digit_err` = 0; `update` = 0.
  - Synchronizer flops reset to {an all 1, seg all 1}.
  - Counter = 0, `captured` = 0.
- Reset mid-stable-period aborts the capture. The pattern must then be re-observed for a full STABLE_CYCLES after reset releases.
- Latency: pins change at edge 0 and stay stable. `update` and the new outputs are visible after edge STABLE_CYCLES+2 (2 cycles of synchronizer, then STABLE_CYCLES samples).
- Any pin change before capture restarts the count, so glitches shorter than STABLE_CYCLES cycles are never captured.
- A held pattern produces exactly one `update`, regardless of duration.
- Returning to the same digit with the same pattern after a different S re-captures and pulses `update` again.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `seg7_pkg`:
  - 7-bit localparams SEG7_0 … SEG7_F holding the 16 active-low encodings. The display encoder uses the same constants, so the two directions cannot drift.
  - Digit width constant (4).
- Sub-module `seg7_pattern_decode`: purely combinational; seg_n[6:0] → {legal, hex[3:0]}.
- Top level holds the synchronizer, stability counter, one-hot check, capture registers and `clear` logic.

## Test plan
- Reset, then hold `an_n` = 1110 and `seg_n` = 0110000 for 20 cycles. Expect exactly one `update` 18 cycles after the change, `digits[3:0]` = 3, `digit_valid` = 0001, `digit_err` = 0000.
- Scan four digits with patterns for 0xC, 0xA, 0xF, 0xE (an_n 1110, 1101, 1011, 0111), 30 cycles each. Expect `digits` = 16'hEFAC and `digit_valid` = 1111.
- Toggle `seg_n` between the patterns for 1 and 7 every 8 cycles with STABLE_CYCLES = 16. Expect no `update` and no output change.
- Capture 0x5 on digit 2, then drive illegal pattern 1111111 on digit 2. Expect `digits[11:8]` to stay 5, `digit_valid[2]` = 0, `digit_err[2]` = 1, one `update`.
- Drive `an_n` = 1100 or 1111 with a stable legal pattern. Expect no `update`. Then assert `clear` in the same cycle as a legal capture. Expect all outputs 0 and no `update`.
- Assert `rst_n` low at count 10 of a stable period, release, and keep the pattern stable. Expect the capture only after a full STABLE_CYCLES+2 cycles following release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions.
// Holds the active-low segment encodings for hex digits 0..F (bit0 = a ... bit6 = g)
// and the digit width. The display encoder and the capture decoder both use these
// constants, so the two directions stay consistent.
package seg7_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [6:0] SEG7_0 = 7'b1000000;
  localparam logic [6:0] SEG7_1 = 7'b1111001;
  localparam logic [6:0] SEG7_2 = 7'b0100100;
  localparam logic [6:0] SEG7_3 = 7'b0110000;
  localparam logic [6:0] SEG7_4 = 7'b0011001;
  localparam logic [6:0] SEG7_5 = 7'b0010010;
  localparam logic [6:0] SEG7_6 = 7'b0000010;
  localparam logic [6:0] SEG7_7 = 7'b1111000;
  localparam logic [6:0] SEG7_8 = 7'b0000000;
  localparam logic [6:0] SEG7_9 = 7'b0010000;
  localparam logic [6:0] SEG7_A = 7'b0001000;
  localparam logic [6:0] SEG7_B = 7'b0000011;
  localparam logic [6:0] SEG7_C = 7'b1000110;
  localparam logic [6:0] SEG7_D = 7'b0100001;
  localparam logic [6:0] SEG7_E = 7'b0000110;
  localparam logic [6:0] SEG7_F = 7'b0001110;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern decoder.
// Ports:
//   seg_n  in  [6:0]  active-low segment pattern (bit0 = a ... bit6 = g)
//   legal  out        pattern is one of the 16 hex encodings
//   hex    out [3:0]  decoded value (0 when illegal)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0]         seg_n,
  output logic               legal,
  output logic [DIGIT_W-1:0] hex
);

  always_comb begin
    legal = 1'b1;
    hex   = '0;
    case (seg_n)
      SEG7_0:  hex = 4'h0;
      SEG7_1:  hex = 4'h1;
      SEG7_2:  hex = 4'h2;
      SEG7_3:  hex = 4'h3;
      SEG7_4:  hex = 4'h4;
      SEG7_5:  hex = 4'h5;
      SEG7_6:  hex = 4'h6;
      SEG7_7:  hex = 4'h7;
      SEG7_8:  hex = 4'h8;
      SEG7_9:  hex = 4'h9;
      SEG7_A:  hex = 4'hA;
      SEG7_B:  hex = 4'hB;
      SEG7_C:  hex = 4'hC;
      SEG7_D:  hex = 4'hD;
      SEG7_E:  hex = 4'hE;
      SEG7_F:  hex = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment display bus.
// Pins are synchronized, filtered for stability, decoded and captured per digit.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   seg_n        active-low segment pattern (bit0 = a ... bit6 = g)
//   an_n         active-low digit select, one-hot expected
//   clear        synchronous clear of all digit status
//   digits       captured hex values, digit i at [4i+3:4i]
//   digit_valid  digit i holds a legally decoded value
//   digit_err    last capture for digit i was an illegal pattern
//   update       one-cycle pulse per capture
module seven_segment_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [6:0]                    seg_n,
  input  logic [NUM_DIGITS-1:0]         an_n,
  input  logic                          clear,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic [NUM_DIGITS-1:0]         digit_err,
  output logic                          update
);

  localparam int unsigned SW   = NUM_DIGITS + 7;
  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  // Sample layout is {an_n, seg_n}; sync2_q is the current sample S.
  logic [SW-1:0] sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic captured_q, captured_d;

  logic [DIGIT_W*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0] valid_q, valid_d, err_q, err_d;
  logic update_q, update_d;

  logic                  change;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [6:0]            seg_s;
  logic                  one_hot;
  logic                  fire;
  logic                  pat_legal;
  logic [DIGIT_W-1:0]    pat_hex;

  // The sample entering S differs from S: the count for the new S starts over.
  assign change  = (sync1_q != sync2_q);
  assign an_sel  = ~sync2_q[SW-1:7];
  assign seg_s   = sync2_q[6:0];
  assign one_hot = ($countones(an_sel) == 1);
  // cnt_q == CntMax means S has been seen STABLE_CYCLES times in a row.
  assign fire    = (cnt_q == CntMax) && !captured_q && one_hot;

  seg7_pattern_decode u_decode (
    .seg_n (seg_s),
    .legal (pat_legal),
    .hex   (pat_hex)
  );

  always_comb begin
    cnt_d      = cnt_q;
    captured_d = captured_q;
    if (change) begin
      cnt_d      = '0;
      captured_d = 1'b0;
    end else begin
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
      // Set even when clear discards the capture, so the held pattern is not re-taken.
      if (fire) captured_d = 1'b1;
    end
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    update_d = 1'b0;
    if (clear) begin
      digits_d = '0;
      valid_d  = '0;
      err_d    = '0;
    end else if (fire) begin
      update_d = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (an_sel[i]) begin
          if (pat_legal) begin
            digits_d[i*DIGIT_W +: DIGIT_W] = pat_hex;
            valid_d[i] = 1'b1;
            err_d[i]   = 1'b0;
          end else begin
            valid_d[i] = 1'b0;
            err_d[i]   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      digits_q   <= '0;
      valid_q    <= '0;
      err_q      <= '0;
      update_q   <= 1'b0;
    end else begin
      sync1_q    <= {an_n, seg_n};
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      update_q   <= update_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign update      = update_q;

endmodule
